iic_req_arbiter: RTL and testbench

- Shares one IIC byte controller (command/busy/fail/data_in interface) between NREQ independent requesters, e.g. EEPROM config, sensor poll and software mailbox.
- Grants round-robin and latches the requester's device ID, word address, data and direction.
- Issues a one-cycle command pulse, tracks controller busy with timeouts, and returns read data plus per-requester done/error.
- Sits between the requester logic and the IIC controller instance.

---
 rtl/iic_req_arbiter_if.sv | 45 ++++
 rtl/iic_req_arbiter.sv | 260 ++++++++++++++++++++++++++
 tb/tb_iic_req_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iic_req_arbiter_if.sv
`default_nettype none
//==========================================================================
// Module   : iic_req_arbiter_if
// Desc     : Requester-side and IIC-controller-side signals of the arbiter.
// Revision : 1.0 - initial release
//==========================================================================
interface iic_req_arbiter_if #(
  parameter int NREQ = 4
);
  // requester side
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   req_wr;
  logic [7*NREQ-1:0] req_dev_id;
  logic [8*NREQ-1:0] req_add;
  logic [8*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]   done;
  logic [NREQ-1:0]   err;
  logic [7:0]        rdata;
  logic              tmo;
  logic [2:0]        gnt_id;
  // IIC byte controller side
  logic [1:0]        iic_command;
  logic [6:0]        iic_dev_id;
  logic [7:0]        iic_add;
  logic [7:0]        iic_data_out;
  logic              iic_busy;
  logic              iic_fail;
  logic [7:0]        iic_data_in;

  // slave: the arbiter itself; master: requesters plus controller around it
  modport slave (
    input  req, req_wr, req_dev_id, req_add, req_wdata,
    input  iic_busy, iic_fail, iic_data_in,
    output done, err, rdata, tmo, gnt_id,
    output iic_command, iic_dev_id, iic_add, iic_data_out
  );

  modport master (
    output req, req_wr, req_dev_id, req_add, req_wdata,
    output iic_busy, iic_fail, iic_data_in,
    input  done, err, rdata, tmo, gnt_id,
    input  iic_command, iic_dev_id, iic_add, iic_data_out
  );
endinterface
`default_nettype wire

// File: rtl/iic_req_arbiter.sv
`default_nettype none
//==========================================================================
// Module   : iic_req_arbiter
// Desc     : Round-robin sharing of one IIC byte controller among NREQ
//            requesters. Optional single retry: IIC_ARB_RETRY_EN.
// Revision : 1.0 - initial release
//==========================================================================
module iic_req_arbiter #(
  parameter int NREQ      = 4,
  parameter int START_TMO = 16,
  parameter int DONE_TMO  = 200000,
  parameter int TMO_W     = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  iic_req_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARB       = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_SAMPLE    = 3'd5,
    S_COMPLETE  = 3'd6
`ifdef IIC_ARB_RETRY_EN
    ,
    S_RETRY     = 3'd7
`endif
  } state_t;

  localparam logic [TMO_W-1:0] c_start_lim = TMO_W'(START_TMO - 1);
  localparam logic [TMO_W-1:0] c_done_lim  = TMO_W'(DONE_TMO - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_rr_ptr;
  logic [2:0]       r_gnt_id;
  logic [TMO_W-1:0] r_cnt;
  logic [TMO_W-1:0] w_cnt_inc;
  logic             r_wr;
  logic [6:0]       r_dev_id;
  logic [7:0]       r_add;
  logic [7:0]       r_wdata;
  logic [7:0]       r_rdata;
  logic             r_fail_flag;
  logic             r_tmo_flag;
  logic             w_err_any;
`ifdef IIC_ARB_RETRY_EN
  logic             r_retried;
`endif

  logic [2:0]       w_winner;
  logic             w_found;
  logic             w_sel_wr;
  logic [6:0]       w_sel_dev;
  logic [7:0]       w_sel_add;
  logic [7:0]       w_sel_wdata;
  logic [NREQ-1:0]  w_gnt_onehot;
  logic [1:0]       w_cmd;
  logic [NREQ-1:0]  w_done;
  logic [NREQ-1:0]  w_err;
  logic             w_tmo;

  // Scan from the pointer upward; descending k lets the nearest hit win.
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req[i] && (((int'(r_rr_ptr) + k) % NREQ) == i)) begin
          w_winner = 3'(i);
          w_found  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_sel_wr    = 1'b0;
    w_sel_dev   = '0;
    w_sel_add   = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_winner == 3'(i)) begin
        w_sel_wr    = bus.req_wr[i];
        w_sel_dev   = bus.req_dev_id[7*i +: 7];
        w_sel_add   = bus.req_add[8*i +: 8];
        w_sel_wdata = bus.req_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    w_gnt_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_gnt_onehot[i] = (r_gnt_id == 3'(i));
    end
  end

  assign w_err_any = r_fail_flag | r_tmo_flag;
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cmd       = '0;
    w_done      = '0;
    w_err       = '0;
    w_tmo       = 1'b0;
    case (r_state)
      S_IDLE: begin
        // a controller still finishing a timed-out job must not see a command
        if ((|bus.req) && !bus.iic_busy) begin
          w_state_nxt = S_ARB;
        end
      end
      S_ARB: begin
        w_state_nxt = w_found ? S_ISSUE : S_IDLE;
      end
      S_ISSUE: begin
        w_cmd       = {r_wr, ~r_wr};
        w_state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (bus.iic_busy) begin
          w_state_nxt = S_WAIT_DONE;
        end else if (r_cnt >= c_start_lim) begin
          w_state_nxt = S_COMPLETE;
        end
      end
      S_WAIT_DONE: begin
        if (!bus.iic_busy) begin
          w_state_nxt = S_SAMPLE;
        end else if (r_cnt >= c_done_lim) begin
          w_state_nxt = S_COMPLETE;
        end
      end
      S_SAMPLE: begin
        w_state_nxt = S_COMPLETE;
      end
      S_COMPLETE: begin
`ifdef IIC_ARB_RETRY_EN
        if (w_err_any && !r_retried) begin
          w_state_nxt = S_RETRY;
        end else
`endif
        begin
          w_done      = w_gnt_onehot;
          w_err       = w_err_any ? w_gnt_onehot : '0;
          w_tmo       = r_tmo_flag;
          w_state_nxt = S_IDLE;
        end
      end
`ifdef IIC_ARB_RETRY_EN
      S_RETRY: begin
        if (!bus.iic_busy) begin
          w_state_nxt = S_ISSUE;
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_gnt_id    <= '0;
      r_wr        <= 1'b0;
      r_dev_id    <= '0;
      r_add       <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_cnt       <= '0;
      r_fail_flag <= 1'b0;
      r_tmo_flag  <= 1'b0;
`ifdef IIC_ARB_RETRY_EN
      r_retried   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_ARB: begin
          if (w_found) begin
            r_gnt_id <= w_winner;
            r_wr     <= w_sel_wr;
            r_dev_id <= w_sel_dev;
            r_add    <= w_sel_add;
            r_wdata  <= w_sel_wdata;
            r_rr_ptr <= (w_winner == 3'(NREQ - 1)) ? 3'd0 : w_winner + 3'd1;
`ifdef IIC_ARB_RETRY_EN
            r_retried <= 1'b0;
`endif
          end
        end
        S_ISSUE: begin
          r_cnt       <= '0;
          r_fail_flag <= 1'b0;
          r_tmo_flag  <= 1'b0;
        end
        S_WAIT_BUSY: begin
          if (bus.iic_busy) begin
            r_cnt <= '0;
          end else if (r_cnt >= c_start_lim) begin
            r_tmo_flag <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_WAIT_DONE: begin
          if (bus.iic_busy) begin
            if (r_cnt >= c_done_lim) begin
              r_tmo_flag <= 1'b1;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        end
        S_SAMPLE: begin
          // a failed read leaves the last good byte in place
          r_fail_flag <= bus.iic_fail;
          if (!r_wr && !bus.iic_fail) begin
            r_rdata <= bus.iic_data_in;
          end
        end
`ifdef IIC_ARB_RETRY_EN
        S_COMPLETE: begin
          if (w_err_any) begin
            r_retried <= 1'b1;
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

  assign bus.done         = w_done;
  assign bus.err          = w_err;
  assign bus.tmo          = w_tmo;
  assign bus.rdata        = r_rdata;
  assign bus.gnt_id       = r_gnt_id;
  assign bus.iic_command  = w_cmd;
  assign bus.iic_dev_id   = r_dev_id;
  assign bus.iic_add      = r_add;
  assign bus.iic_data_out = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_iic_req_arbiter.sv
`default_nettype none
//==========================================================================
// Module   : tb_iic_req_arbiter
// Desc     : Randomized bench for iic_req_arbiter with an IIC controller
//            model and a transaction-level round-robin reference model.
// Revision : 1.0 - initial release
//==========================================================================
module tb_iic_req_arbiter;

  localparam int NREQ      = 4;
  localparam int START_TMO = 16;
  localparam int DONE_TMO  = 60;
  localparam int TMO_W     = 18;
  localparam int CLK_P     = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #(CLK_P/2) clk = ~clk;

  iic_req_arbiter_if #(.NREQ(NREQ)) bus ();

  iic_req_arbiter #(
    .NREQ      (NREQ),
    .START_TMO (START_TMO),
    .DONE_TMO  (DONE_TMO),
    .TMO_W     (TMO_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // requester state
  bit [NREQ-1:0] req_v;
  bit            wr_v   [NREQ];
  bit [6:0]      dev_v  [NREQ];
  bit [7:0]      add_v  [NREQ];
  bit [7:0]      wd_v   [NREQ];

  // reference model
  int       mptr;
  bit [7:0] model_rdata;

  // controller model configuration and observation
  int       cfg_start_dly;   // <0: busy never rises
  int       cfg_busy_len;
  bit       cfg_stuck;
  bit       cfg_fail;
  bit [7:0] cfg_rdata;
  int       cmd_cnt = 0;
  logic [1:0] last_cmd;
  logic [6:0] last_dev;
  logic [7:0] last_add;
  logic [7:0] last_data;
  time      last_cmd_time;

  task automatic drive_reqs();
    for (int i = 0; i < NREQ; i++) begin
      bus.req[i]              = req_v[i];
      bus.req_wr[i]           = wr_v[i];
      bus.req_dev_id[7*i +: 7] = dev_v[i];
      bus.req_add[8*i +: 8]   = add_v[i];
      bus.req_wdata[8*i +: 8] = wd_v[i];
    end
  endtask

  task automatic set_req(input int i, input bit wr, input bit [6:0] dev,
                         input bit [7:0] add, input bit [7:0] wd);
    req_v[i] = 1'b1;
    wr_v[i]  = wr;
    dev_v[i] = dev;
    add_v[i] = add;
    wd_v[i]  = wd;
    drive_reqs();
  endtask

  task automatic set_cfg(input int sd, input int bl, input bit st, input bit f, input bit [7:0] rd);
    cfg_start_dly = sd;
    cfg_busy_len  = bl;
    cfg_stuck     = st;
    cfg_fail      = f;
    cfg_rdata     = rd;
  endtask

  function automatic int model_pick();
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (mptr + k) % NREQ;
      if (req_v[i]) return i;
    end
    return -1;
  endfunction

  // IIC controller model
  initial begin : ctl_model
    int phase;
    int cnt;
    bit prev_cmd;
    phase = 0;
    cnt = 0;
    prev_cmd = 1'b0;
    bus.iic_busy    = 1'b0;
    bus.iic_fail    = 1'b0;
    bus.iic_data_in = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        phase = 0;
        prev_cmd = 1'b0;
        bus.iic_busy = 1'b0;
        bus.iic_fail = 1'b0;
      end else begin
        if (prev_cmd) check_eq("cmd_one_cycle", 32'(bus.iic_command), 0);
        prev_cmd = (bus.iic_command != 2'b00);
        if (bus.iic_command != 2'b00) begin
          check_eq("cmd_not_while_busy", 32'(bus.iic_busy), 0);
          cmd_cnt++;
          last_cmd      = bus.iic_command;
          last_dev      = bus.iic_dev_id;
          last_add      = bus.iic_add;
          last_data     = bus.iic_data_out;
          last_cmd_time = $time;
          if (phase == 0 && cfg_start_dly >= 0) begin
            bus.iic_fail = 1'b0;
            cnt   = cfg_start_dly;
            phase = 1;
          end
        end else begin
          case (phase)
            1: begin
              if (cnt == 0) begin
                bus.iic_busy    = 1'b1;
                bus.iic_data_in = 8'($urandom);
                cnt   = cfg_busy_len;
                phase = 2;
              end else begin
                cnt--;
              end
            end
            2: begin
              if (cnt <= 0 && !cfg_stuck) begin
                bus.iic_busy    = 1'b0;
                bus.iic_fail    = cfg_fail;
                bus.iic_data_in = cfg_rdata;
                phase = 0;
              end else if (cnt > 0) begin
                cnt--;
              end
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

  task automatic expect_txn(input bit drop_early);
    int          w;
    int          c0;
    bit          seen;
    bit          e_tmo;
    bit          e_err;
    bit          start_tmo;
    bit [7:0]    e_rdata;
    bit          e_wr;
    bit [6:0]    e_dev;
    bit [7:0]    e_add;
    bit [7:0]    e_wd;
    bit [NREQ-1:0] onehot;
    w = model_pick();
    if (w < 0) return;
    e_wr      = wr_v[w];
    e_dev     = dev_v[w];
    e_add     = add_v[w];
    e_wd      = wd_v[w];
    onehot    = NREQ'(1) << w;
    start_tmo = (cfg_start_dly < 0);
    e_tmo     = start_tmo || cfg_stuck;
    e_err     = e_tmo || cfg_fail;
    e_rdata   = (!e_err && !e_wr) ? cfg_rdata : model_rdata;
    c0        = cmd_cnt;
    seen      = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (drop_early && cmd_cnt > c0 && req_v[w]) begin
        req_v[w] = 1'b0;
        drive_reqs();
      end
      if (bus.done != '0) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("done_seen", 32'(seen), 1);
    if (seen) begin
      check_eq("done", 32'(bus.done), 32'(onehot));
      check_eq("gnt_id", 32'(bus.gnt_id), w);
      check_eq("err", 32'(bus.err), e_err ? 32'(onehot) : 0);
      check_eq("tmo", 32'(bus.tmo), 32'(e_tmo));
      check_eq("rdata", 32'(bus.rdata), 32'(e_rdata));
      check_eq("cmd_count", cmd_cnt - c0, 1);
      check_eq("cmd_code", 32'(last_cmd), {30'd0, e_wr, ~e_wr});
      check_eq("cmd_dev", 32'(last_dev), 32'(e_dev));
      check_eq("cmd_add", 32'(last_add), 32'(e_add));
      check_eq("cmd_data", 32'(last_data), 32'(e_wd));
      if (start_tmo) begin
        check_eq("start_tmo_latency", 32'(($time - last_cmd_time) / CLK_P), START_TMO + 1);
      end
    end
    req_v[w] = 1'b0;
    drive_reqs();
    mptr        = (w + 1) % NREQ;
    model_rdata = e_rdata;
    @(negedge clk);
    check_eq("done_pulse_end", 32'(bus.done), 0);
    check_eq("err_quiet", 32'(bus.err), 0);
  endtask

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_done"},  32'(bus.done), 0);
    check_eq({pfx, "_err"},   32'(bus.err), 0);
    check_eq({pfx, "_rdata"}, 32'(bus.rdata), 0);
    check_eq({pfx, "_tmo"},   32'(bus.tmo), 0);
    check_eq({pfx, "_gnt"},   32'(bus.gnt_id), 0);
    check_eq({pfx, "_cmd"},   32'(bus.iic_command), 0);
    check_eq({pfx, "_dev"},   32'(bus.iic_dev_id), 0);
    check_eq({pfx, "_add"},   32'(bus.iic_add), 0);
    check_eq({pfx, "_dout"},  32'(bus.iic_data_out), 0);
  endtask

  initial begin : watchdog
    #(CLK_P * 60000);
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit seen;
    int c0;
    req_v       = '0;
    mptr        = 0;
    model_rdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      wr_v[i] = 1'b0; dev_v[i] = '0; add_v[i] = '0; wd_v[i] = '0;
    end
    drive_reqs();
    set_cfg(1, 2, 1'b0, 1'b0, 8'h00);

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // all four at once: round-robin from pointer 0
    for (int i = 0; i < NREQ; i++) begin
      set_req(i, 1'($urandom_range(1)), 7'($urandom), 8'($urandom), 8'($urandom));
    end
    for (int t = 0; t < NREQ; t++) begin
      set_cfg(int'($urandom_range(3)), int'($urandom_range(4)), 1'b0, 1'b0, 8'($urandom));
      expect_txn(1'b0);
    end
    set_req(1, 1'b0, 7'h21, 8'h31, 8'h41);
    set_req(3, 1'b1, 7'h23, 8'h33, 8'h43);
    for (int t = 0; t < 2; t++) begin
      set_cfg(0, 1, 1'b0, 1'b0, 8'($urandom));
      expect_txn(1'b0);
    end

    // single read on requester 0
    set_cfg(1, 3, 1'b0, 1'b0, 8'hA5);
    set_req(0, 1'b0, 7'h50, 8'h10, 8'h00);
    expect_txn(1'b0);

    // write with controller fail
    set_cfg(2, 2, 1'b0, 1'b1, 8'h77);
    set_req(2, 1'b1, 7'h2A, 8'h44, 8'h3C);
    expect_txn(1'b0);

    // busy never rises
    set_cfg(-1, 0, 1'b0, 1'b0, 8'h00);
    set_req(1, 1'b0, 7'h11, 8'h22, 8'h33);
    expect_txn(1'b0);

    // busy stuck high, next request must wait in IDLE
    set_cfg(1, 0, 1'b1, 1'b0, 8'h00);
    set_req(3, 1'b0, 7'h13, 8'h24, 8'h35);
    expect_txn(1'b0);
    set_req(0, 1'b1, 7'h05, 8'h06, 8'h07);
    c0 = cmd_cnt;
    repeat (20) @(negedge clk);
    check_eq("idle_while_busy_cmds", cmd_cnt - c0, 0);
    check_eq("idle_while_busy_done", 32'(bus.done), 0);
    set_cfg(0, 2, 1'b0, 1'b0, 8'h5A);
    expect_txn(1'b0);

    // reset during WAIT_DONE
    set_cfg(0, 30, 1'b0, 1'b0, 8'h00);
    set_req(1, 1'b0, 7'h61, 8'h62, 8'h63);
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.iic_busy) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("busy_rose_before_reset", 32'(seen), 1);
    repeat (3) @(negedge clk);
    check_eq("in_flight_gnt", 32'(bus.gnt_id), 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    mptr        = 0;
    model_rdata = '0;
    set_req(3, 1'b1, 7'h73, 8'h74, 8'h75);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    set_cfg(1, 1, 1'b0, 1'b0, 8'hC3);
    expect_txn(1'b0);
    set_cfg(1, 1, 1'b0, 1'b0, 8'h3C);
    expect_txn(1'b0);

    // randomized traffic
    for (int r = 0; r < 80; r++) begin
      int mode;
      for (int i = 0; i < NREQ; i++) begin
        if (!req_v[i] && $urandom_range(2) == 0) begin
          set_req(i, 1'($urandom_range(1)), 7'($urandom), 8'($urandom), 8'($urandom));
        end
      end
      if (req_v == '0) begin
        set_req(int'($urandom_range(NREQ - 1)), 1'($urandom_range(1)),
                7'($urandom), 8'($urandom), 8'($urandom));
      end
      mode = int'($urandom_range(9));
      if (mode == 0) begin
        set_cfg(-1, 0, 1'b0, 1'b0, 8'($urandom));
      end else begin
        set_cfg(int'($urandom_range(4)), int'($urandom_range(6)), 1'b0,
                mode == 1, 8'($urandom));
      end
      expect_txn($urandom_range(3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
